trig_arb: RTL and testbench

TRIG_ARB -- requirements
Module: trig_arb

---
 rtl/trig_arb.sv | 158 +++++++++++++++
 tb/tb_trig_arb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_arb.sv
//==============================================================================
// Module   : trig_arb
// Purpose  : Two-requester round-robin arbiter in front of one shared trig
//            unit. One request in flight at a time; illegal modes are
//            answered immediately with an error response.
// Options  : define TRIG_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT
//            cycles without u_done (error response, data 16'hFFFF).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module trig_arb #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    input  logic        r1_valid,
    output logic        r0_ready,
    output logic        r1_ready,
    input  logic [15:0] r0_phase,
    input  logic [15:0] r1_phase,
    input  logic [6:0]  r0_mode,
    input  logic [6:0]  r1_mode,
    output logic [15:0] a,
    output logic [6:0]  b,
    output logic        u_start,
    input  logic        u_done,
    input  logic [15:0] u_res,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [6:0] c_MODE_COS = 7'd0;
    localparam logic [6:0] c_MODE_SIN = 7'd1;

    // A TIMEOUT outside 1..255 does not fit the 8-bit wait counter.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("trig_arb: TIMEOUT must be in 1..255");
    end

    state_t      r_state;
    logic        r_last_grant;
    logic        w_grant;
    logic        w_accept;
    logic [15:0] w_sel_phase;
    logic [6:0]  w_sel_mode;
    logic        w_mode_legal;

`ifdef TRIG_ARB_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_wait_cnt;
`endif

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        w_grant = r_last_grant;
        if (r0_valid && r1_valid) begin
            w_grant = ~r_last_grant;
        end else if (r0_valid) begin
            w_grant = 1'b0;
        end else if (r1_valid) begin
            w_grant = 1'b1;
        end
    end

    // Handshake and operand selection for the granted requester.
    always_comb begin
        r0_ready     = (r_state == S_IDLE) && !rst && !w_grant && r0_valid;
        r1_ready     = (r_state == S_IDLE) && !rst &&  w_grant && r1_valid;
        w_accept     = r0_ready || r1_ready;
        w_sel_phase  = w_grant ? r1_phase : r0_phase;
        w_sel_mode   = w_grant ? r1_mode  : r0_mode;
        w_mode_legal = (w_sel_mode == c_MODE_COS) || (w_sel_mode == c_MODE_SIN);
    end

    // Control FSM with registered operands, start pulse and response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            a            <= 16'h0000;
            b            <= 7'd0;
            u_start      <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_data     <= 16'h0000;
            rsp_err      <= 1'b0;
`ifdef TRIG_ARB_TIMEOUT_EN
            r_wait_cnt   <= 8'd0;
`endif
        end else begin
            u_start   <= 1'b0;
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        a      <= w_sel_phase;
                        b      <= w_sel_mode;
                        rsp_id <= w_grant;
                        if (w_mode_legal) begin
                            u_start <= 1'b1;
                            r_state <= S_ISSUE;
                        end else begin
                            // Illegal mode never reaches the unit.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= 16'h0000;
                            r_state   <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    // u_done in the start cycle is deliberately ignored.
                    r_state <= S_WAIT;
`ifdef TRIG_ARB_TIMEOUT_EN
                    r_wait_cnt <= 8'd0;
`endif
                end
                S_WAIT: begin
                    // A completion in the expiry cycle still counts as success.
                    if (u_done) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= u_res;
                        r_state   <= S_RESP;
`ifdef TRIG_ARB_TIMEOUT_EN
                    end else if (r_wait_cnt == c_TIMEOUT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= 16'hFFFF;
                        r_state   <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
`endif
                    end
                end
                S_RESP: begin
                    r_last_grant <= rsp_id;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trig_arb.sv
//==============================================================================
// Module   : tb_trig_arb
// Purpose  : Directed self-checking bench for trig_arb. Honours
//            TRIG_ARB_TIMEOUT_EN for the timeout scenario.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_trig_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [15:0] r0_phase, r1_phase;
    logic [6:0]  r0_mode, r1_mode;
    logic [15:0] a;
    logic [6:0]  b;
    logic        u_start;
    logic        u_done;
    logic [15:0] u_res;
    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;

    trig_arb #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .r0_phase(r0_phase), .r1_phase(r1_phase),
        .r0_mode(r0_mode), .r1_mode(r1_mode),
        .a(a), .b(b), .u_start(u_start),
        .u_done(u_done), .u_res(u_res),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a"},     32'(a),         32'h0);
        check({tag, "_b"},     32'(b),         32'h0);
        check({tag, "_start"}, 32'(u_start),   32'h0);
        check({tag, "_rv"},    32'(rsp_valid), 32'h0);
        check({tag, "_id"},    32'(rsp_id),    32'h0);
        check({tag, "_data"},  32'(rsp_data),  32'h0);
        check({tag, "_err"},   32'(rsp_err),   32'h0);
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 10 && !u_start; i++) tick();
        check(tag, 32'(u_start), 32'h1);
    endtask

    initial begin
        logic [15:0] ph;
        int          nrsp;

        rst = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
        r0_phase = '0; r1_phase = '0; r0_mode = '0; r1_mode = '0;
        u_done = 1'b0; u_res = '0;

        // Reset values; readies stay low while rst is high.
        tick(); tick();
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        check("rst_r0_ready", 32'(r0_ready), 32'h0);
        check("rst_r1_ready", 32'(r1_ready), 32'h0);
        check_reset_outputs("rst");
        r0_valid = 1'b0; r1_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Legal SIN request from r0, unit answers k=3 cycles after start.
        r0_valid = 1'b1; r0_phase = 16'h02FF; r0_mode = 7'd1;
        #1;
        check("t1_r0_ready_T", 32'(r0_ready), 32'h1);
        check("t1_r1_ready_T", 32'(r1_ready), 32'h0);
        tick();                                   // T+1
        r0_valid = 1'b0;
        check("t1_start_T1", 32'(u_start), 32'h1);
        check("t1_a",        32'(a),       32'h02FF);
        check("t1_b",        32'(b),       32'h1);
        check("t1_rv_T1",    32'(rsp_valid), 32'h0);
        tick();                                   // T+2
        check("t1_start_T2", 32'(u_start), 32'h0);
        tick();                                   // T+3
        tick();                                   // T+4
        u_done = 1'b1; u_res = 16'h1234;
        check("t1_rv_T4", 32'(rsp_valid), 32'h0);
        tick();                                   // T+5
        u_done = 1'b0; u_res = 16'h0000;
        check("t1_rv_T5",   32'(rsp_valid), 32'h1);
        check("t1_id",      32'(rsp_id),    32'h0);
        check("t1_data",    32'(rsp_data),  32'h1234);
        check("t1_err",     32'(rsp_err),   32'h0);
        tick();                                   // T+6
        check("t1_rv_T6",   32'(rsp_valid), 32'h0);
        check("t1_hold",    32'(rsp_data),  32'h1234);

        // Illegal mode from r1: immediate error response, no start.
        r1_valid = 1'b1; r1_phase = 16'h1111; r1_mode = 7'd5;
        #1;
        check("t3_r1_ready", 32'(r1_ready), 32'h1);
        check("t3_r0_ready", 32'(r0_ready), 32'h0);
        tick();                                   // T+1
        r1_valid = 1'b0;
        check("t3_start", 32'(u_start),   32'h0);
        check("t3_rv",    32'(rsp_valid), 32'h1);
        check("t3_id",    32'(rsp_id),    32'h1);
        check("t3_err",   32'(rsp_err),   32'h1);
        check("t3_data",  32'(rsp_data),  32'h0);
        check("t3_b",     32'(b),         32'h5);
        tick();
        check("t3_rv_off",  32'(rsp_valid), 32'h0);
        check("t3_err_hold", 32'(rsp_err),  32'h1);
        tick();

        // Unit never answers.
        r0_valid = 1'b1; r0_phase = 16'h0010; r0_mode = 7'd0;
        tick();                                   // T+1
        r0_valid = 1'b0;
        check("t4_start", 32'(u_start), 32'h1);
`ifdef TRIG_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin         // WAIT cycles T+2..T+5
            tick();
            check("t4_rv_wait", 32'(rsp_valid), 32'h0);
        end
        tick();                                   // T+6
        check("t4_rv",   32'(rsp_valid), 32'h1);
        check("t4_err",  32'(rsp_err),   32'h1);
        check("t4_data", 32'(rsp_data),  32'hFFFF);
        tick();
        tick();
        // Completion in the expiry cycle is a normal result.
        r0_valid = 1'b1;
        tick();                                   // T+1
        r0_valid = 1'b0;
        tick(); tick(); tick(); tick();           // T+5
        u_done = 1'b1; u_res = 16'h0055;
        tick();                                   // T+6
        u_done = 1'b0;
        check("t4b_rv",   32'(rsp_valid), 32'h1);
        check("t4b_err",  32'(rsp_err),   32'h0);
        check("t4b_data", 32'(rsp_data),  32'h0055);
        tick();
`else
        nrsp = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rsp_valid) nrsp++;
        end
        check("t4_no_rsp", 32'(nrsp), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        // Reset during WAIT, then a late u_done.
        r0_valid = 1'b1; r0_phase = 16'h4000; r0_mode = 7'd0;
        tick();                                   // T+1
        r0_valid = 1'b0;
        check("t5_start", 32'(u_start), 32'h1);
        tick();                                   // T+2 (WAIT)
        rst = 1'b1;
        tick();
        check_reset_outputs("t5_rst");
        rst = 1'b0; u_done = 1'b1; u_res = 16'h7777;
        tick();
        u_done = 1'b0;
        check("t5_rv_a", 32'(rsp_valid), 32'h0);
        tick();
        check("t5_rv_b", 32'(rsp_valid), 32'h0);
        r1_valid = 1'b1; r1_phase = 16'h0ABC; r1_mode = 7'd1;
        #1;
        check("t5_r1_ready", 32'(r1_ready), 32'h1);
        tick();                                   // T+1
        r1_valid = 1'b0;
        check("t5_start2", 32'(u_start), 32'h1);
        check("t5_a",      32'(a),       32'h0ABC);
        tick();                                   // T+2
        tick();                                   // T+3
        u_done = 1'b1; u_res = 16'h0BCD;
        tick();                                   // T+4
        u_done = 1'b0;
        check("t5_rv",   32'(rsp_valid), 32'h1);
        check("t5_id",   32'(rsp_id),    32'h1);
        check("t5_data", 32'(rsp_data),  32'h0BCD);
        check("t5_err",  32'(rsp_err),   32'h0);
        tick();

        // Fresh reset, both requesters valid: r0 wins first, then alternate.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        r0_valid = 1'b1; r0_phase = 16'h0100; r0_mode = 7'd0;
        r1_valid = 1'b1; r1_phase = 16'h0200; r1_mode = 7'd1;
        for (int i = 0; i < 4; i++) begin
            wait_start("t2_start");
            check("t2_a", 32'(a), (i % 2) ? 32'h0200 : 32'h0100);
            tick();
            u_done = 1'b1; u_res = 16'(i + 16'h00A0);
            tick();
            u_done = 1'b0;
            check("t2_rv",   32'(rsp_valid), 32'h1);
            check("t2_id",   32'(rsp_id),    32'(i % 2));
            check("t2_data", 32'(rsp_data),  32'(i + 16'h00A0));
            if (i == 3) begin
                r0_valid = 1'b0; r1_valid = 1'b0;
            end
        end
        tick();

        // Stray u_done in IDLE/ISSUE/RESP; operands follow each request.
        u_done = 1'b1; u_res = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_stray_rv", 32'(rsp_valid), 32'h0);
        end
        ph = 16'h0000;
        for (int i = 1; i <= 3; i++) begin
            ph = ph + 16'h02FF;
            r0_valid = 1'b1; r0_phase = ph; r0_mode = (i % 2) ? 7'd1 : 7'd0;
            tick();                               // T+1
            r0_valid = 1'b0;
            check("t6_start", 32'(u_start),   32'h1);
            check("t6_a",     32'(a),         32'(ph));
            check("t6_b",     32'(b),         (i % 2) ? 32'h1 : 32'h0);
            check("t6_rv_T1", 32'(rsp_valid), 32'h0);
            tick();                               // T+2
            u_done = 1'b0;
            check("t6_rv_T2", 32'(rsp_valid), 32'h0);
            tick();                               // T+3
            check("t6_rv_T3", 32'(rsp_valid), 32'h0);
            u_done = 1'b1; u_res = 16'(i);
            tick();                               // T+4
            check("t6_rv",   32'(rsp_valid), 32'h1);
            check("t6_data", 32'(rsp_data),  32'(i));
            tick();                               // T+5
            check("t6_rv_off", 32'(rsp_valid), 32'h0);
        end
        u_done = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
